unzoom_scanner: RTL and testbench

- Inverse of the coordinate zoomer. The zoomer maps a screen pixel to a source pixel (source = screen >> Zoom). This block takes one source pixel and emits, one per beat, every screen pixel that maps to it: a 2^Zoom x 2^Zoom block in raster order.
- Sits between the source-pixel fetch stage and the frame-buffer write port.
- Uses a ready/valid handshake on both sides.

---
 rtl/unzoom_scanner_if.sv | 35 +++
 rtl/unzoom_scanner.sv | 182 ++++++++++++++++++
 tb/tb_unzoom_scanner.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/unzoom_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unzoom_scanner_if                                                            |
// | Request channel (source pixel) and beat channel (screen pixel) bundle.       |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
interface unzoom_scanner_if #(
  parameter int W  = 8,
  parameter int ZW = 8
);
  logic          ENB;
  logic [W-1:0]  Xsrc;
  logic [W-1:0]  Ysrc;
  logic [ZW-1:0] Zoom;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [W-1:0]  Xout;
  logic [W-1:0]  Yout;
  logic          VALID;
  logic          READY;
  logic          LAST;
  logic          CLIP;

  // Upstream fetch stage and downstream write port, seen from the stimulus side
  modport master (
    output ENB, Xsrc, Ysrc, Zoom, REQ_VALID, READY,
    input  REQ_READY, Xout, Yout, VALID, LAST, CLIP
  );

  modport slave (
    input  ENB, Xsrc, Ysrc, Zoom, REQ_VALID, READY,
    output REQ_READY, Xout, Yout, VALID, LAST, CLIP
  );
endinterface
`default_nettype wire

// File: rtl/unzoom_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unzoom_scanner                                                               |
// | Expands one source pixel into its 2^z x 2^z screen block in raster order.    |
// | Optional macro UNZOOM_CLIP_EN: clip the block to the screen, drop off-screen |
// | requests with a CLIP pulse; undefined, coordinates wrap mod 2^W.             |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module unzoom_scanner #(
  parameter int W        = 8,
  parameter int ZW       = 8,
  parameter int MAX_ZOOM = 7
) (
  input  wire logic          ACLK,
  input  wire logic          ARESETN,
  unzoom_scanner_if.slave    bus
);

  localparam int CW  = MAX_ZOOM + 1;
  localparam int ZSW = (MAX_ZOOM > 0) ? $clog2(MAX_ZOOM + 1) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]  r_bx;
  logic [W-1:0]  r_by;
  logic [CW-1:0] r_nx;
  logic [CW-1:0] r_ny;
  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [W-1:0]  r_xout;
  logic [W-1:0]  r_yout;
  logic          r_valid;
  logic          r_last;
  logic          r_clip;

  logic [ZSW-1:0] w_z;
  logic [CW-1:0]  w_n;
  logic [W-1:0]   w_bx;
  logic [W-1:0]   w_by;
  logic [CW-1:0]  w_nx;
  logic [CW-1:0]  w_ny;
  logic           w_clip;

  logic           w_req_ready;
  logic           w_accept;
  logic           w_valid;
  logic           w_advance;
  logic           w_x_end;
  logic [CW-1:0]  w_i_nxt;
  logic [CW-1:0]  w_j_nxt;
  logic           w_last_nxt;

  // Effective zoom saturates at MAX_ZOOM
  assign w_z = (bus.Zoom > ZW'(MAX_ZOOM)) ? ZSW'(MAX_ZOOM) : bus.Zoom[ZSW-1:0];
  assign w_n = CW'(1) << w_z;

`ifdef UNZOOM_CLIP_EN
  localparam int           BW     = W + MAX_ZOOM;
  localparam logic [W:0]   c_span = (W + 1)'(1) << W;

  logic [BW-1:0] w_bx_full;
  logic [BW-1:0] w_by_full;
  logic [W:0]    w_room_x;
  logic [W:0]    w_room_y;

  assign w_bx_full = BW'(bus.Xsrc) << w_z;
  assign w_by_full = BW'(bus.Ysrc) << w_z;
  assign w_bx      = w_bx_full[W-1:0];
  assign w_by      = w_by_full[W-1:0];
  assign w_clip    = (|w_bx_full[BW-1:W]) | (|w_by_full[BW-1:W]);

  // Pixels left on screen from the block origin; only meaningful when not clipped
  assign w_room_x  = c_span - {1'b0, w_bx};
  assign w_room_y  = c_span - {1'b0, w_by};
  assign w_nx      = ((W + 1)'(w_n) < w_room_x) ? w_n : w_room_x[CW-1:0];
  assign w_ny      = ((W + 1)'(w_n) < w_room_y) ? w_n : w_room_y[CW-1:0];
`else
  assign w_bx   = bus.Xsrc << w_z;
  assign w_by   = bus.Ysrc << w_z;
  assign w_clip = 1'b0;
  assign w_nx   = w_n;
  assign w_ny   = w_n;
`endif

  // Raster successor of the current beat
  assign w_x_end    = (r_i == (r_nx - CW'(1)));
  assign w_i_nxt    = w_x_end ? '0 : (r_i + CW'(1));
  assign w_j_nxt    = w_x_end ? (r_j + CW'(1)) : r_j;
  assign w_last_nxt = (w_i_nxt == (r_nx - CW'(1))) && (w_j_nxt == (r_ny - CW'(1)));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_accept    = 1'b0;
    w_valid     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Held low during the clip pulse so a dropped request is never back-to-back
        w_req_ready = bus.ENB & ~r_clip & ARESETN;
        w_accept    = w_req_ready & bus.REQ_VALID;
        if (w_accept && !w_clip) begin
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        w_valid   = r_valid & bus.ENB;
        w_advance = w_valid & bus.READY;
        if (w_advance && r_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bx    <= '0;
      r_by    <= '0;
      r_nx    <= '0;
      r_ny    <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_xout  <= '0;
      r_yout  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_clip  <= 1'b0;
    end else begin
      r_clip <= w_accept & w_clip;
      if (w_accept) begin
        r_bx    <= w_bx;
        r_by    <= w_by;
        r_nx    <= w_nx;
        r_ny    <= w_ny;
        r_i     <= '0;
        r_j     <= '0;
        r_xout  <= w_bx;
        r_yout  <= w_by;
        r_valid <= ~w_clip;
        r_last  <= ~w_clip & (w_nx == CW'(1)) & (w_ny == CW'(1));
      end else if (w_advance) begin
        if (r_last) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_i    <= w_i_nxt;
          r_j    <= w_j_nxt;
          r_xout <= r_bx + W'(w_i_nxt);
          r_yout <= r_by + W'(w_j_nxt);
          r_last <= w_last_nxt;
        end
      end
    end
  end

  assign bus.REQ_READY = w_req_ready;
  assign bus.VALID     = w_valid;
  assign bus.Xout      = r_xout;
  assign bus.Yout      = r_yout;
  assign bus.LAST      = r_last;
  assign bus.CLIP      = r_clip;

endmodule
`default_nettype wire

// File: tb/tb_unzoom_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_unzoom_scanner                                                            |
// | Directed bench: raster order, stalls, enable drop, zoom saturation, reset.   |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module tb_unzoom_scanner;

  logic ACLK = 1'b0;
  logic ARESETN;
  int   n_checks = 0;
  int   n_fails  = 0;

  unzoom_scanner_if #(.W(8), .ZW(8)) bus ();

  unzoom_scanner #(.W(8), .ZW(8), .MAX_ZOOM(7)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Present a request and wait through its accept edge
  task automatic send(input logic [7:0] xs, input logic [7:0] ys, input logic [7:0] zoom);
    int guard = 0;
    bus.Xsrc      = xs;
    bus.Ysrc      = ys;
    bus.Zoom      = zoom;
    bus.REQ_VALID = 1'b1;
    #1;
    while (!bus.REQ_READY && guard < 20) begin
      step();
      guard++;
    end
    check("req_ready_before_accept", bus.REQ_READY, 1);
    step();
    bus.REQ_VALID = 1'b0;
    #1;
  endtask

  // Expect beats (bx+i, by+j) in raster order; stall uses READY pattern 1,0,0
  task automatic collect(input logic [7:0] bx, input logic [7:0] by, input int nx, input int ny,
                         input bit stall, input int drop_at, input int stop_at);
    int         beats   = 0;
    int         k       = 0;
    int         total   = nx * ny;
    int         limit   = total * 4 + 40;
    bit         dropped = 1'b0;
    bit         rdy;
    logic [7:0] ex;
    logic [7:0] ey;
    check("first_beat_valid", bus.VALID, 1);
    check("scan_req_ready", bus.REQ_READY, 0);
    while (beats < stop_at && k < limit) begin
      ex = bx + 8'(beats % nx);
      ey = by + 8'(beats / nx);
      if (!dropped && beats == drop_at) begin
        dropped = 1'b1;
        bus.ENB = 1'b0;
        repeat (3) begin
          step();
          check("enb_low_valid", bus.VALID, 0);
          check("enb_low_hold_x", bus.Xout, ex);
          check("enb_low_hold_y", bus.Yout, ey);
        end
        bus.ENB = 1'b1;
        #1;
      end
      rdy = stall ? (k % 3 == 0) : 1'b1;
      bus.READY = rdy;
      if (bus.VALID) begin
        check("beat_x", bus.Xout, ex);
        check("beat_y", bus.Yout, ey);
        check("beat_last", bus.LAST, (beats == total - 1));
        if (rdy) beats++;
      end
      step();
      k++;
    end
    if (beats < stop_at) check("beat_timeout", beats, stop_at);
    bus.READY = 1'b1;
  endtask

  task automatic check_done(input string tag);
    check({tag, "_valid_after"}, bus.VALID, 0);
    check({tag, "_req_ready_after"}, bus.REQ_READY, 1);
  endtask

`ifdef UNZOOM_CLIP_EN
  task automatic check_clip(input string tag);
    check({tag, "_clip_pulse"}, bus.CLIP, 1);
    check({tag, "_clip_no_valid"}, bus.VALID, 0);
    step();
    check({tag, "_clip_clear"}, bus.CLIP, 0);
    check({tag, "_clip_no_valid2"}, bus.VALID, 0);
    check({tag, "_clip_req_ready"}, bus.REQ_READY, 1);
  endtask
`endif

  initial begin
    ARESETN       = 1'b0;
    bus.ENB       = 1'b1;
    bus.Xsrc      = '0;
    bus.Ysrc      = '0;
    bus.Zoom      = '0;
    bus.REQ_VALID = 1'b0;
    bus.READY     = 1'b1;
    #12;
    check("rst_xout", bus.Xout, 0);
    check("rst_yout", bus.Yout, 0);
    check("rst_valid", bus.VALID, 0);
    check("rst_last", bus.LAST, 0);
    check("rst_clip", bus.CLIP, 0);
    check("rst_req_ready", bus.REQ_READY, 0);
    ARESETN = 1'b1;
    step();
    check("idle_req_ready", bus.REQ_READY, 1);

    // Zoom 0: single beat
    send(8'h10, 8'hF0, 8'd0);
    collect(8'h10, 8'hF0, 1, 1, 1'b0, -1, 1);
    check_done("z0");

    // Zoom 1: 2x2 block at (6,10)
    send(8'd3, 8'd5, 8'd1);
    collect(8'd6, 8'd10, 2, 2, 1'b0, -1, 4);
    check_done("z1");

    // Zoom 2 with READY stalls and an enable drop
    send(8'd1, 8'd1, 8'd2);
    collect(8'd4, 8'd4, 4, 4, 1'b1, 6, 16);
    check_done("z2");

    // Block origin 0x100: dropped when clipping, wraps to X 0..15 otherwise
    send(8'h10, 8'h00, 8'd4);
`ifdef UNZOOM_CLIP_EN
    check_clip("z4");
`else
    collect(8'h00, 8'h00, 16, 16, 1'b0, -1, 256);
    check_done("z4wrap");
`endif

    // Block touching the bottom-right corner
    send(8'h1F, 8'h1F, 8'd3);
    collect(8'd248, 8'd248, 8, 8, 1'b0, -1, 64);
    check_done("z3edge");

`ifdef UNZOOM_CLIP_EN
    // Zoom 8 saturates to 7, origin 256 is off-screen
    send(8'd2, 8'd0, 8'd8);
    check_clip("z8");
`endif

    // Zoom 10 saturates to 7
    send(8'd0, 8'd0, 8'd10);
    collect(8'd0, 8'd0, 128, 128, 1'b0, -1, 16384);
    check_done("zsat");

    // Async reset mid-scan
    send(8'd1, 8'd1, 8'd2);
    collect(8'd4, 8'd4, 4, 4, 1'b0, -1, 5);
    #2;
    ARESETN = 1'b0;
    #1;
    check("arst_xout", bus.Xout, 0);
    check("arst_yout", bus.Yout, 0);
    check("arst_valid", bus.VALID, 0);
    check("arst_last", bus.LAST, 0);
    check("arst_clip", bus.CLIP, 0);
    check("arst_req_ready", bus.REQ_READY, 0);
    #2;
    ARESETN = 1'b1;
    step();
    check("post_rst_req_ready", bus.REQ_READY, 1);
    repeat (3) begin
      check("post_rst_no_beat", bus.VALID, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
